// File: rtl/taus_pkg.sv
// taus_pkg: shared FSM states, seed minimums, masks and shift amounts for the Tausworthe state generator.
package taus_pkg;
  typedef enum logic [2:0] {LOAD0, LOAD1, LOAD2, WARM, RUN} state_t;
  localparam logic [31:0] MIN0 = 32'd2;
  localparam logic [31:0] MIN1 = 32'd8;
  localparam logic [31:0] MIN2 = 32'd16;
  localparam logic [31:0] MASK0 = 32'hFFFFFFFE;
  localparam logic [31:0] MASK1 = 32'hFFFFFFF8;
  localparam logic [31:0] MASK2 = 32'hFFFFFFF0;
  localparam int SA0 = 13, SB0 = 19, SC0 = 12;
  localparam int SA1 = 2, SB1 = 25, SC1 = 4;
  localparam int SA2 = 3, SB2 = 11, SC2 = 17;
  // Minimums are powers of two, so OR-ing one in lifts any too-small word above it.
  function automatic logic [31:0] fix_seed(input logic [31:0] w, input logic [31:0] m);
    return (w < m) ? (w | m) : w;
  endfunction
endpackage

// File: rtl/taus_step.sv
// taus_step: one combinational Tausworthe advance of the three component states.
module taus_step
  import taus_pkg::*;
(
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  output logic [31:0] n0,
  output logic [31:0] n1,
  output logic [31:0] n2
);
  assign n0 = ((s0 & MASK0) << SC0) ^ (((s0 << SA0) ^ s0) >> SB0);
  assign n1 = ((s1 & MASK1) << SC1) ^ (((s1 << SA1) ^ s1) >> SB1);
  assign n2 = ((s2 & MASK2) << SC2) ^ (((s2 << SA2) ^ s2) >> SB2);
endmodule

// File: rtl/taus_state_gen.sv
// taus_state_gen: seed loading with correction, optional warm-up, and per-cycle Tausworthe state advance.
// Defining TAUS_STEP_CNT_EN adds a step_count output counting advances since the last s0 capture.
module taus_state_gen
  import taus_pkg::*;
#(
  parameter int WARMUP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        seed_valid,
  output logic        seed_ready,
  input  logic [31:0] seed_data,
  output logic [31:0] s0,
  output logic [31:0] s1,
  output logic [31:0] s2,
  output logic        out_valid,
  output logic        seed_fixed
`ifdef TAUS_STEP_CNT_EN
  ,
  output logic [31:0] step_count
`endif
);
  localparam logic [7:0] WLAST = 8'(WARMUP - 1);
  state_t state, nxt;
  logic [7:0] warm_cnt;
  logic [31:0] n0, n1, n2;
  logic acc, cap0, adv;
  assign seed_ready = state != WARM;
  assign out_valid = state == RUN;
  assign acc = seed_valid && seed_ready;
  assign cap0 = acc && (state == LOAD0 || state == RUN);
  // A seed transfer in RUN wins over the ce-driven advance.
  assign adv = state == WARM || (state == RUN && ce && !acc);
  taus_step u_step (.s0(s0), .s1(s1), .s2(s2), .n0(n0), .n1(n1), .n2(n2));
  always_comb begin
    nxt = state;
    case (state)
      LOAD0: nxt = acc ? LOAD1 : LOAD0;
      LOAD1: nxt = acc ? LOAD2 : LOAD1;
      LOAD2: nxt = acc ? (WARMUP > 0 ? WARM : RUN) : LOAD2;
      WARM: nxt = (warm_cnt == WLAST) ? RUN : WARM;
      RUN: nxt = acc ? LOAD1 : RUN;
      default: nxt = LOAD0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD0;
      warm_cnt <= 8'd0;
      s0 <= 32'd0;
      s1 <= 32'd0;
      s2 <= 32'd0;
      seed_fixed <= 1'b0;
    end else begin
      state <= nxt;
      warm_cnt <= (state == WARM) ? warm_cnt + 8'd1 : 8'd0;
      if (cap0) begin
        s0 <= fix_seed(seed_data, MIN0);
        seed_fixed <= seed_data < MIN0;
      end else if (acc && state == LOAD1) begin
        s1 <= fix_seed(seed_data, MIN1);
        seed_fixed <= seed_fixed | (seed_data < MIN1);
      end else if (acc && state == LOAD2) begin
        s2 <= fix_seed(seed_data, MIN2);
        seed_fixed <= seed_fixed | (seed_data < MIN2);
      end else if (adv) begin
        s0 <= n0;
        s1 <= n1;
        s2 <= n2;
      end
    end
  end
`ifdef TAUS_STEP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_count <= 32'd0;
    else if (cap0) step_count <= 32'd0;
    else if (adv) step_count <= step_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_taus_state_gen.sv
// tb_taus_state_gen: scoreboard bench for taus_state_gen with WARMUP=0 (u0) and WARMUP=8 (u8) instances.
module tb_taus_state_gen;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, sv0 = 1'b0, sv8 = 1'b0;
  logic [31:0] sd = 32'd0;
  logic rdy0, rdy8, ov0, ov8, fx0, fx8;
  logic [31:0] a0, a1, a2, b0, b1, b2;
`ifdef TAUS_STEP_CNT_EN
  logic [31:0] sc0, sc8;
`endif
  logic [97:0] o0, o8, e;
  logic [97:0] q[$];
  logic [31:0] m0, m1, m2, mcnt;
  logic mfx;
  int mst;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign o0 = {a0, a1, a2, ov0, fx0};
  assign o8 = {b0, b1, b2, ov8, fx8};
  taus_state_gen #(.WARMUP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .seed_valid(sv0), .seed_ready(rdy0), .seed_data(sd),
    .s0(a0), .s1(a1), .s2(a2), .out_valid(ov0), .seed_fixed(fx0)
`ifdef TAUS_STEP_CNT_EN
    , .step_count(sc0)
`endif
  );
  taus_state_gen #(.WARMUP(8)) u8 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .seed_valid(sv8), .seed_ready(rdy8), .seed_data(sd),
    .s0(b0), .s1(b1), .s2(b2), .out_valid(ov8), .seed_fixed(fx8)
`ifdef TAUS_STEP_CNT_EN
    , .step_count(sc8)
`endif
  );
  function automatic logic [95:0] mstep(input logic [95:0] s);
    logic [31:0] x, y, z;
    x = s[95:64];
    y = s[63:32];
    z = s[31:0];
    return {((x & 32'hFFFFFFFE) << 12) ^ (((x << 13) ^ x) >> 19),
            ((y & 32'hFFFFFFF8) << 4) ^ (((y << 2) ^ y) >> 25),
            ((z & 32'hFFFFFFF0) << 17) ^ (((z << 3) ^ z) >> 11)};
  endfunction
  function automatic logic [31:0] fixw(input logic [31:0] w, input logic [31:0] m);
    return (w < m) ? (w | m) : w;
  endfunction
  task automatic model_reset();
    {m0, m1, m2, mcnt} = '0;
    mfx = 1'b0;
    mst = 0;
    q.delete();
  endtask
  // Drives one u0 cycle, pushes the expected post-edge outputs, and returns at the next negedge.
  task automatic cyc0(input logic v, input logic [31:0] d, input logic c);
    sv0 = v;
    sd = d;
    ce = c;
    if (v) begin
      if (mst == 0 || mst == 3) begin
        m0 = fixw(d, 32'd2);
        mfx = d < 32'd2;
        mst = 1;
        mcnt = 32'd0;
      end else if (mst == 1) begin
        m1 = fixw(d, 32'd8);
        mfx = mfx | (d < 32'd8);
        mst = 2;
      end else begin
        m2 = fixw(d, 32'd16);
        mfx = mfx | (d < 32'd16);
        mst = 3;
      end
    end else if (mst == 3 && c) begin
      {m0, m1, m2} = mstep({m0, m1, m2});
      mcnt = mcnt + 32'd1;
    end
    q.push_back({m0, m1, m2, mst == 3, mfx});
    @(negedge clk);
    sv0 = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (o0 !== 98'd0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_u0 got=%h rdy=%b want=0 rdy=1", o0, rdy0);
    end
    total++;
    if (o8 !== 98'd0 || rdy8 !== 1'b1) begin
      bad++;
      $display("FAIL reset_u8 got=%h rdy=%b want=0 rdy=1", o8, rdy8);
    end
`ifdef TAUS_STEP_CNT_EN
    total++;
    if (sc0 !== 32'd0 || sc8 !== 32'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d/%0d want=0", sc0, sc8);
    end
`endif
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_seed_fix();
    for (int i = 0; i < 3; i++) begin
      cyc0(1'b1, 32'd0, 1'b0);
      e = q.pop_front();
      total++;
      if (o0 !== e) begin
        bad++;
        $display("FAIL fix_load%0d got=%h want=%h", i, o0, e);
      end
    end
    total++;
    if ({a0, a1, a2, ov0, fx0} !== {32'd2, 32'd8, 32'd16, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL fix_const got=%h want=2/8/16 valid fixed", o0);
    end
    cyc0(1'b0, 32'd0, 1'b1);
    e = q.pop_front();
    total++;
    if (o0 !== e) begin
      bad++;
      $display("FAIL fix_step got=%h want=%h", o0, e);
    end
    total++;
    if ({a0, a1, a2} !== {32'd8192, 32'd128, 32'd2097152}) begin
      bad++;
      $display("FAIL step_const got=%0d/%0d/%0d want=8192/128/2097152", a0, a1, a2);
    end
  endtask
  task automatic test_hold();
    logic [31:0] w[3];
    w = '{32'd5, 32'd9, 32'd17};
    for (int i = 0; i < 3; i++) begin
      cyc0(1'b1, w[i], 1'b0);
      e = q.pop_front();
      total++;
      if (o0 !== e) begin
        bad++;
        $display("FAIL hold_load%0d got=%h want=%h", i, o0, e);
      end
    end
    total++;
    if ({a0, a1, a2, ov0, fx0} !== {32'd5, 32'd9, 32'd17, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL hold_const got=%h want=5/9/17 valid unfixed", o0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc0(1'b0, 32'd0, 1'b0);
      e = q.pop_front();
      total++;
      if (o0 !== e) begin
        bad++;
        $display("FAIL hold_ce0_%0d got=%h want=%h", i, o0, e);
      end
    end
  endtask
  task automatic test_reload();
    logic [31:0] w[3];
    w = '{32'd3, 32'd12, 32'd20};
    for (int i = 0; i < 3; i++) begin
      cyc0(1'b0, 32'd0, 1'b1);
      e = q.pop_front();
      total++;
      if (o0 !== e) begin
        bad++;
        $display("FAIL reload_run%0d got=%h want=%h", i, o0, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc0(1'b1, w[i], 1'b1);
      e = q.pop_front();
      total++;
      if (o0 !== e) begin
        bad++;
        $display("FAIL reload_load%0d got=%h want=%h", i, o0, e);
      end
      if (i == 0) begin
        total++;
        if (ov0 !== 1'b0 || a0 !== 32'd3) begin
          bad++;
          $display("FAIL reload_first got valid=%b s0=%0d want valid=0 s0=3", ov0, a0);
        end
      end
    end
    total++;
    if ({a0, a1, a2, ov0} !== {32'd3, 32'd12, 32'd20, 1'b1}) begin
      bad++;
      $display("FAIL reload_const got=%h want=3/12/20 valid", o0);
    end
  endtask
  task automatic test_warmup();
    logic [31:0] w[3];
    logic [95:0] t;
    int low, n;
    w = '{32'd2, 32'd8, 32'd16};
    ce = 1'b0;
    t = {32'd2, 32'd8, 32'd16};
    for (int i = 0; i < 8; i++) t = mstep(t);
    for (int i = 0; i < 3; i++) begin
      sv8 = 1'b1;
      sd = w[i];
      if (i == 2) q.push_back({t, 1'b1, 1'b0});
      @(negedge clk);
      sv8 = 1'b0;
    end
    low = 0;
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin
      if (rdy8 === 1'b0) low++;
      @(negedge clk);
      n++;
    end
    total++;
    if (ov8 !== 1'b1) begin
      bad++;
      $display("FAIL warm_timeout got valid=%b want=1 within 20 cycles", ov8);
    end
    total++;
    if (low != 8 || n != 8) begin
      bad++;
      $display("FAIL warm_ready got low=%0d cycles=%0d want 8/8", low, n);
    end
    e = q.pop_front();
    total++;
    if (o8 !== e) begin
      bad++;
      $display("FAIL warm_state got=%h want=%h", o8, e);
    end
`ifdef TAUS_STEP_CNT_EN
    total++;
    if (sc8 !== 32'd8) begin
      bad++;
      $display("FAIL warm_count got=%0d want=8", sc8);
    end
`endif
  endtask
  task automatic test_reset_midload();
    logic [31:0] w[2];
    w = '{32'd7, 32'd9};
    for (int i = 0; i < 2; i++) begin
      cyc0(1'b1, w[i], 1'b0);
      e = q.pop_front();
      total++;
      if (o0 !== e) begin
        bad++;
        $display("FAIL mid_load%0d got=%h want=%h", i, o0, e);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (o0 !== 98'd0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL mid_async got=%h rdy=%b want=0 rdy=1", o0, rdy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc0(1'b1, 32'd100, 1'b0);
    e = q.pop_front();
    total++;
    if (o0 !== e || a0 !== 32'd100 || a1 !== 32'd0) begin
      bad++;
      $display("FAIL mid_reload got=%h want=%h", o0, e);
    end
    cyc0(1'b1, 32'd200, 1'b0);
    cyc0(1'b1, 32'd300, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = q.pop_front();
    end
    total++;
    if (o0 !== e) begin
      bad++;
      $display("FAIL mid_finish got=%h want=%h", o0, e);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      cyc0(1'b0, 32'd0, 1'($urandom_range(0, 1)));
      e = q.pop_front();
      total++;
      if (o0 !== e) begin
        bad++;
        if (bad < 20) $display("FAIL rand_%0d got=%h want=%h", i, o0, e);
      end
      total++;
      if (a0 == 32'd0 || a1 == 32'd0 || a2 == 32'd0) begin
        bad++;
        if (bad < 20) $display("FAIL rand_zero_%0d got=%h want nonzero components", i, o0);
      end
    end
`ifdef TAUS_STEP_CNT_EN
    total++;
    if (sc0 !== mcnt) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d", sc0, mcnt);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_seed_fix();
    test_hold();
    test_reload();
    test_warmup();
    test_reset_midload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
